// File: rtl/dice_roller_gen2_if.sv
// Key-side / display-side signal bundle for the dice roller.
interface dice_roller_gen2_if #(
    parameter int OUT_W = 4
);
    logic             i_start;
    logic             i_stop;
    logic [OUT_W-1:0] o_random_out;
    logic [OUT_W-1:0] o_prev;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_stop,
        input  o_random_out, o_prev, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop,
        output o_random_out, o_prev, o_busy, o_done
    );
endinterface

// File: rtl/dice_roller_gen2.sv
// Decelerating LFSR dice roller: counter-seeded, geometric slow-down over
// NUM_STAGES stages, early stop, zero-lock protection and previous-result hold.
module dice_roller_gen2 #(
    parameter int              OUT_W       = 4,
    parameter int              LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 'h002D,
    parameter int              NUM_STAGES  = 5,
    parameter int              STAGE_LEN   = 13_427_772,
    parameter int              BASE_PERIOD = 1_678_472
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    dice_roller_gen2_if.slave        bus
);
    localparam int MAX_P  = BASE_PERIOD << (NUM_STAGES - 1);
    localparam int TICK_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int SC_W   = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
    localparam int SG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic {IDLE, ROLL} state_t;

    state_t            state, state_n;
    logic [LFSR_W-1:0] seed_cnt;
    logic [LFSR_W-1:0] lfsr, lfsr_n, lfsr_step;
    logic [TICK_W-1:0] tick, tick_n;
    logic [SC_W-1:0]   stage_cnt, stage_cnt_n;
    logic [SG_W-1:0]   stage, stage_n;
    logic [OUT_W-1:0]  rnd, rnd_n, prev, prev_n;
    logic              done, done_n;
    logic              tick_hit, stage_end, last;

    function automatic logic [LFSR_W-1:0] nz(input logic [LFSR_W-1:0] v);
        return (v == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : v;
    endfunction

    assign lfsr_step = {^(lfsr & TAPS), lfsr[LFSR_W-1:1]};
    // Period compare done at 64 bits so BASE_PERIOD << stage never truncates.
    assign tick_hit  = (64'(tick) == ((64'(BASE_PERIOD) << stage) - 64'd1));
    assign stage_end = (stage_cnt == SC_W'(STAGE_LEN - 1));
    assign last      = stage_end && (stage == SG_W'(NUM_STAGES - 1));

    always_comb begin
        state_n     = state;
        lfsr_n      = lfsr;
        tick_n      = tick;
        stage_cnt_n = stage_cnt;
        stage_n     = stage;
        rnd_n       = rnd;
        prev_n      = prev;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    lfsr_n      = nz(lfsr ^ seed_cnt);
                    prev_n      = rnd;
                    tick_n      = '0;
                    stage_cnt_n = '0;
                    stage_n     = '0;
                    state_n     = ROLL;
                end
            end
            ROLL: begin
                lfsr_n = nz(lfsr_step);
                if (bus.i_stop || last) begin
                    rnd_n   = lfsr[OUT_W-1:0];
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    if (tick_hit) begin
                        rnd_n  = lfsr[OUT_W-1:0];
                        tick_n = '0;
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                    // Stage boundary restarts the tick so each stage begins a fresh period.
                    if (stage_end) begin
                        stage_cnt_n = '0;
                        tick_n      = '0;
                        stage_n     = stage + 1'b1;
                    end else begin
                        stage_cnt_n = stage_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            seed_cnt  <= '0;
            lfsr      <= {{(LFSR_W-1){1'b0}}, 1'b1};
            tick      <= '0;
            stage_cnt <= '0;
            stage     <= '0;
            rnd       <= '0;
            prev      <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            seed_cnt  <= seed_cnt + 1'b1;
            lfsr      <= lfsr_n;
            tick      <= tick_n;
            stage_cnt <= stage_cnt_n;
            stage     <= stage_n;
            rnd       <= rnd_n;
            prev      <= prev_n;
            done      <= done_n;
        end
    end

    assign bus.o_random_out = rnd;
    assign bus.o_prev       = prev;
    assign bus.o_busy       = (state == ROLL);
    assign bus.o_done       = done;
endmodule

// File: tb/tb_dice_roller_gen2.sv
// Directed + randomized bench for dice_roller_gen2 against a roll-schedule model.
module tb_dice_roller_gen2;
    localparam int OUT_W = 4, LFSR_W = 16, NS = 3, SL = 8, BP = 2;
    localparam logic [15:0] TAPS = 16'h002D;
    localparam int ROLL_LEN = NS * SL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dice_roller_gen2_if #(.OUT_W(OUT_W)) bus ();

    dice_roller_gen2 #(
        .OUT_W(OUT_W), .LFSR_W(LFSR_W), .TAPS(TAPS),
        .NUM_STAGES(NS), .STAGE_LEN(SL), .BASE_PERIOD(BP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    int ncmp = 0;
    int nfail = 0;

    // Reference model: state of a roll is just "which roll cycle are we in".
    logic [15:0] m_seed, m_lfsr;
    logic [3:0]  m_out, m_prev;
    bit          m_roll, m_done;
    int          m_c;

    function automatic logic [15:0] fixz(input logic [15:0] v);
        return (v == 16'h0) ? 16'h1 : v;
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] v);
        return fixz({^(v & TAPS), v[15:1]});
    endfunction

    // Roll cycle c shows a new value when it closes a full period of its stage.
    function automatic bit is_update(input int c);
        int s, j;
        s = c / SL;
        j = c % SL;
        return ((j + 1) % (BP << s)) == 0;
    endfunction

    task automatic model_reset();
        m_seed = 16'h0; m_lfsr = 16'h1; m_out = 4'h0; m_prev = 4'h0;
        m_roll = 0; m_done = 0; m_c = 0;
    endtask

    task automatic model_step(input bit s, input bit p);
        m_done = 0;
        if (!m_roll) begin
            if (s) begin
                m_lfsr = fixz(m_lfsr ^ m_seed);
                m_prev = m_out;
                m_roll = 1;
                m_c    = 0;
            end
        end else begin
            if (p || m_c == ROLL_LEN - 1) begin
                m_out  = m_lfsr[3:0];
                m_roll = 0;
                m_done = 1;
            end else if (is_update(m_c)) begin
                m_out = m_lfsr[3:0];
            end
            m_lfsr = adv(m_lfsr);
            m_c++;
        end
        m_seed = m_seed + 16'h1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_out"},  32'(bus.o_random_out), 32'(m_out));
        chk({tag, "_prev"}, 32'(bus.o_prev),       32'(m_prev));
        chk({tag, "_busy"}, 32'(bus.o_busy),       32'(m_roll));
        chk({tag, "_done"}, 32'(bus.o_done),       32'(m_done));
    endtask

    // Called #1 after a rising edge; drives inputs for the next edge then checks.
    task automatic cyc(input bit s, input bit p, input string tag);
        bus.i_start = s;
        bus.i_stop  = p;
        model_step(s, p);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        check_outs(tag);
    endtask

    task automatic roll(input int stop_at, input bit noise, input string tag,
                        output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        cyc(1'b1, 1'b0, tag);
        nbusy += int'(bus.o_busy);
        for (int c = 0; c < 40 && m_roll; c++) begin
            cyc(noise ? bit'($urandom_range(0, 1)) : 1'b0, c == stop_at, tag);
            nbusy += int'(bus.o_busy);
            ndone += int'(bus.o_done);
        end
    endtask

    task automatic wait_seed(input logic [15:0] v, input string tag);
        for (int k = 0; k < 70000 && m_seed != v; k++) cyc(1'b0, 1'b0, tag);
        chk({tag, "_seed"}, 32'(dut.seed_cnt), 32'(v));
    endtask

    initial begin
        int nb, nd, nz_cnt;
        logic [3:0] first_final;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;

        // Power-on reset, then the zero-seed corner on the very next edges.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outs("rst");
        chk("rst_lfsr", 32'(dut.lfsr), 32'h1);
        chk("rst_seed", 32'(dut.seed_cnt), 32'h0);

        cyc(1'b0, 1'b0, "lock_idle");
        chk("lock_seed", 32'(dut.seed_cnt), 32'h1);
        cyc(1'b1, 1'b0, "lock_start");
        chk("lock_lfsr", 32'(dut.lfsr), 32'h1);
        nz_cnt = 0;
        for (int c = 0; c < ROLL_LEN + 2; c++) begin
            cyc(1'b0, 1'b0, "lock_roll");
            if (bus.o_random_out != 4'h0) nz_cnt++;
        end
        chk("lock_nonzero", 32'(nz_cnt != 0), 32'h1);

        // Full roll started at seed 0xA5 after a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_seed(16'h00A5, "full");
        roll(-1, 1'b0, "full", nb, nd);
        chk("full_busy_len", 32'(nb), 32'(ROLL_LEN));
        chk("full_done_cnt", 32'(nd), 32'h1);

        // Back-to-back: second start accepted in the done cycle.
        first_final = m_out;
        cyc(1'b1, 1'b0, "b2b_start");
        chk("b2b_prev", 32'(bus.o_prev), 32'(first_final));
        chk("b2b_hold", 32'(bus.o_random_out), 32'(first_final));
        cyc(1'b0, 1'b0, "b2b_c0");
        chk("b2b_done_low", 32'(bus.o_done), 32'h0);
        for (int c = 0; c < 40 && m_roll; c++) cyc(1'b0, 1'b0, "b2b_roll");

        // Early stop at roll cycle 9 with start noise during the roll.
        repeat (3) cyc(1'b0, 1'b1, "stop_idle");
        roll(9, 1'b1, "stop", nb, nd);
        chk("stop_busy_len", 32'(nb), 32'd10);
        chk("stop_done_cnt", 32'(nd), 32'h1);
        repeat (4) cyc(1'b0, 1'b0, "stop_after");

        // Randomized gaps and stop points.
        for (int r = 0; r < 6; r++) begin
            int gap, sp;
            gap = $urandom_range(0, 15);
            sp  = $urandom_range(0, 30);
            for (int g = 0; g < gap; g++) cyc(1'b0, bit'($urandom_range(0, 1)), "rnd_idle");
            roll(sp < ROLL_LEN ? sp : -1, 1'b1, "rnd", nb, nd);
            chk("rnd_busy_len", 32'(nb), 32'(sp < ROLL_LEN ? sp + 1 : ROLL_LEN));
        end

        // Reset asserted mid-roll at roll cycle 12.
        cyc(1'b1, 1'b0, "mr_start");
        for (int c = 0; c < 12; c++) cyc(1'b0, 1'b0, "mr_roll");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("mr_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outs("mr_hold");
        end
        rst = 1'b0;
        wait_seed(16'h00A5, "mr_again");
        roll(-1, 1'b0, "mr_again", nb, nd);
        chk("mr_busy_len", 32'(nb), 32'(ROLL_LEN));
        chk("mr_done_cnt", 32'(nd), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
